fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Owns the PC and issues single-outstanding requests to instruction memory over a req/gnt + rvalid handshake. Holds each fetched instruction and its PC in a one-entry output buffer with valid/ready toward decode. Accepts branch/jump redirects from execute and flushes wrong-path work.

---
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// holds one fetched instruction for decode, flushing wrong-path work on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef enum logic {StFetch, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q, discard_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        req_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            discard_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            discard_q   <= discard_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        discard_d   = discard_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StFetch: begin
                if (req_fire) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d   = StFetch;
                    discard_d = 1'b0;
                    if (!discard_q && !redirect_valid) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = imem_rdata;
                        out_pc_d    = fetch_pc_q;
                    end
                end
            end
            default: state_d = StFetch;
        endcase

        // Redirect wins over everything; a request still in flight after this edge is wrong-path.
        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            if ((state_q == StWait && !imem_rvalid) || (state_q == StFetch && req_fire)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (!rst && state_q == StFetch) begin
            imem_req = !out_valid_q || out_ready;
        end
        req_fire  = imem_req && imem_gnt;
        imem_addr = pc_q;
        out_valid = out_valid_q;
        out_inst  = out_inst_q;
        out_pc    = out_pc_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset sequence, and a randomized run
// checked against a program-order model of the instruction stream seen by decode.
module tb_fetch_stage;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int ncmp = 0;
    int nfail = 0;

    fetch_stage #(.RESET_PC(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic g, input logic rv, input logic [31:0] rd, input logic rx,
                       input logic [31:0] rp, input logic rdy, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                       input logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rx; v.rpc = rp; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_5a5a;
    endfunction

    task automatic drive_idle();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    endtask

    // Randomized-run state: memory model and expected program order
    logic        outstanding;
    int unsigned delay;
    logic [31:0] maddr;
    logic [31:0] exp_pc;
    int          ncons;
    logic        have_prev, prev_addr_keep, prev_hold;
    logic [31:0] prev_addr, prev_pc, prev_inst;
    logic        fire, cons;

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", imem_addr, B);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        rst = 1'b0;

        // gnt rvalid rdata redir rpc ready | req addr valid pc inst
        add(1, 0, 0,            0, 0,            1, 1, B,            0, 0,            0);
        add(0, 1, 32'ha0a0_0000, 0, 0,           1, 0, B + 4,        0, 0,            0);
        add(1, 0, 0,            0, 0,            1, 1, B + 4,        1, B,            32'ha0a0_0000);
        add(0, 1, 32'ha1a1_0001, 0, 0,           0, 0, B + 8,        0, 0,            0);
        add(1, 0, 0,            0, 0,            0, 0, B + 8,        1, B + 4,        32'ha1a1_0001);
        add(1, 0, 0,            0, 0,            0, 0, B + 8,        1, B + 4,        32'ha1a1_0001);
        add(1, 0, 0,            0, 0,            1, 1, B + 8,        1, B + 4,        32'ha1a1_0001);
        add(0, 0, 0,            1, 32'h1c00_0103, 1, 0, B + 12,      0, 0,            0);
        add(0, 1, 32'hbad0_0001, 0, 0,           1, 0, 32'h1c00_0100, 0, 0,           0);
        add(1, 0, 0,            0, 0,            1, 1, 32'h1c00_0100, 0, 0,           0);
        add(0, 1, 32'hc0c0_0000, 0, 0,           1, 0, 32'h1c00_0104, 0, 0,           0);
        add(0, 0, 0,            1, 32'h1c00_0200, 0, 0, 32'h1c00_0104, 1, 32'h1c00_0100,
            32'hc0c0_0000);
        add(1, 0, 0,            1, 32'h1c00_0300, 1, 1, 32'h1c00_0200, 0, 0,           0);
        add(0, 1, 32'hbad0_0002, 0, 0,           1, 0, 32'h1c00_0300, 0, 0,           0);
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 0,        0, 0,            1, 1, 32'h1c00_0300, 0, 0,           0);
        end
        add(1, 0, 0,            0, 0,            1, 1, 32'h1c00_0300, 0, 0,           0);
        add(0, 1, 32'hbad0_0003, 1, 32'h1c00_0400, 1, 0, 32'h1c00_0304, 0, 0,         0);
        add(1, 0, 0,            0, 0,            1, 1, 32'h1c00_0400, 0, 0,           0);
        add(0, 1, 32'hd0d0_0000, 0, 0,           1, 0, 32'h1c00_0404, 0, 0,           0);
        add(0, 0, 0,            0, 0,            1, 1, 32'h1c00_0404, 1, 32'h1c00_0400,
            32'hd0d0_0000);
        add(0, 0, 0,            0, 0,            1, 1, 32'h1c00_0404, 0, 0,           0);

        foreach (vecs[i]) begin
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
            redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            out_ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_inst", i), out_inst, vecs[i].e_inst);
            end
            @(negedge clk);
        end

        // Async reset while a request is in flight
        drive_idle();
        imem_gnt = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, B);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_resume_req", {31'd0, imem_req}, 32'd1);
        chk("arst_resume_addr", imem_addr, B);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'he0e0_0000;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk("arst_first_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_first_pc", out_pc, B);
        chk("arst_first_inst", out_inst, 32'he0e0_0000);

        // Randomized run
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        outstanding = 1'b0; delay = 0; maddr = '0; exp_pc = B; ncons = 0;
        have_prev = 1'b0; prev_addr_keep = 1'b0; prev_hold = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_inst = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_rvalid = outstanding && (delay == 0);
            imem_rdata = imem_rvalid ? memf(maddr) : $urandom;
            imem_gnt = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (imem_addr[1:0] != 2'b00) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (have_prev && prev_addr_keep) chk("addr_stable", imem_addr, prev_addr);
            if (have_prev && prev_hold) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_pc", out_pc, prev_pc);
                chk("hold_inst", out_inst, prev_inst);
            end
            if (outstanding && imem_req) chk("single_outstanding", 32'd1, 32'd0);
            cons = out_valid && out_ready;
            if (cons) begin
                chk("cons_pc", out_pc, exp_pc);
                chk("cons_inst", out_inst, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            fire = imem_req && imem_gnt;
            if (imem_rvalid) outstanding = 1'b0;
            else if (outstanding && delay > 0) delay--;
            if (fire) begin
                outstanding = 1'b1;
                delay = $urandom_range(0, 2);
                maddr = imem_addr;
            end
            have_prev = 1'b1;
            prev_addr_keep = !fire && !redirect_valid;
            prev_addr = imem_addr;
            prev_hold = out_valid && !out_ready && !redirect_valid;
            prev_pc = out_pc;
            prev_inst = out_inst;
            @(negedge clk);
        end
        ncmp++;
        if (ncons < 200) begin
            nfail++;
            $display("FAIL progress: got %0d consumed instructions, expected at least 200", ncons);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
